// File: rtl/spi_target_pkg.sv
// Shared constants and FSM state type for the SPI mode-0 memory target.
package spi_target_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDID  = 8'h9F;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_RDATA  = 3'd3,
        ST_WDATA  = 3'd4,
        ST_IGNORE = 3'd5
    } state_e;

endpackage

// File: rtl/spi_target_sync.sv
// Oversampling front end: synchronises SCLK, CS and MOSI into the system clock
// domain and derives SCLK rise/fall and CS fall strobes.
module spi_target_sync
    import spi_target_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk_i,
    input  logic spi_cs_i,
    input  logic spi_mosi_i,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n,
    output logic cs_fall,
    output logic mosi
);

    logic [SYNC_DEPTH-1:0] sclk_sr;
    logic [SYNC_DEPTH-1:0] cs_sr;
    logic [SYNC_DEPTH-1:0] mosi_sr;
    logic                  sclk_d;
    logic                  cs_d;

    // CS stages reset to "asserted" so a CS held low through reset never
    // looks like a fresh falling edge; only a real high->low restarts a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr <= '0;
            cs_sr   <= '0;
            mosi_sr <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_DEPTH-2:0], spi_clk_i};
            cs_sr   <= {cs_sr[SYNC_DEPTH-2:0], spi_cs_i};
            mosi_sr <= {mosi_sr[SYNC_DEPTH-2:0], spi_mosi_i};
            sclk_d  <= sclk_sr[SYNC_DEPTH-1];
            cs_d    <= cs_sr[SYNC_DEPTH-1];
        end
    end

    assign sclk_rise = sclk_sr[SYNC_DEPTH-1] & ~sclk_d;
    assign sclk_fall = ~sclk_sr[SYNC_DEPTH-1] & sclk_d;
    assign cs_n      = cs_sr[SYNC_DEPTH-1];
    assign cs_fall   = cs_d & ~cs_sr[SYNC_DEPTH-1];
    assign mosi      = mosi_sr[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_target_mem.sv
// SPI mode-0 target emulating a 2^ADDR_W byte SRAM (READ/WRITE, optional RDID).
// Optional RDID command is enabled by defining SPI_TARGET_RDID_EN.
module spi_target_mem
    import spi_target_pkg::*;
#(
    parameter int unsigned ADDR_W    = 4,
    parameter logic [7:0]  DEVICE_ID = 8'hA5
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              spi_clk_i,
    input  logic              spi_cs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oeb_o,
    output logic              wr_stb_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_n;
    logic cs_fall;
    logic mosi;

    spi_target_sync u_sync (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_n_i),
        .spi_clk_i  (spi_clk_i),
        .spi_cs_i   (spi_cs_i),
        .spi_mosi_i (spi_mosi_i),
        .sclk_rise  (sclk_rise),
        .sclk_fall  (sclk_fall),
        .cs_n       (cs_n),
        .cs_fall    (cs_fall),
        .mosi       (mosi)
    );

    state_e            state;
    state_e            state_nx;
    logic [2:0]        bit_cnt;
    logic [2:0]        out_cnt;
    logic [6:0]        shift_in;
    logic [7:0]        shift_out;
    logic [ADDR_W-1:0] ptr;
    logic              is_write;
    logic              is_rdid;
    logic [7:0]        mem [DEPTH];

    logic [7:0]        byte_in;
    logic              byte_done;
    logic              op_bad;

    assign byte_in   = {shift_in, mosi};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        op_bad   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cs_fall) state_nx = ST_CMD;
            end
            ST_CMD: begin
                if (byte_done) begin
                    if (byte_in == OP_READ || byte_in == OP_WRITE) begin
                        state_nx = ST_ADDR;
                    end
`ifdef SPI_TARGET_RDID_EN
                    else if (byte_in == OP_RDID) begin
                        state_nx = ST_RDATA;
                    end
`endif
                    else begin
                        state_nx = ST_IGNORE;
                        op_bad   = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (byte_done) state_nx = is_write ? ST_WDATA : ST_RDATA;
            end
            ST_RDATA, ST_WDATA, ST_IGNORE: begin
                state_nx = state;
            end
            default: state_nx = ST_IDLE;
        endcase
        // CS release wins over everything, but the datapath still commits a
        // byte completing in this same cycle because it keys off current state.
        if (state != ST_IDLE && cs_n) state_nx = ST_IDLE;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            bit_cnt   <= '0;
            out_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            ptr       <= '0;
            is_write  <= 1'b0;
            is_rdid   <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            err_o     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_stb_o <= 1'b0;
            err_o    <= op_bad;
            if (state == ST_IDLE) begin
                bit_cnt   <= '0;
                out_cnt   <= '0;
                shift_in  <= '0;
                shift_out <= '0;
            end else begin
                if (sclk_rise) begin
                    shift_in <= byte_in[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        unique case (state)
                            ST_CMD: begin
                                is_write <= (byte_in == OP_WRITE);
`ifdef SPI_TARGET_RDID_EN
                                is_rdid  <= (byte_in == OP_RDID);
`endif
                            end
                            ST_ADDR: begin
                                ptr <= byte_in[ADDR_W-1:0];
                            end
                            ST_WDATA: begin
                                mem[ptr]  <= byte_in;
                                wr_stb_o  <= 1'b1;
                                wr_addr_o <= ptr;
                                wr_data_o <= byte_in;
                                ptr       <= ptr + ADDR_W'(1);
                            end
                            default: ;
                        endcase
                    end
                end
                // First fall in RDATA loads a byte; every 8th fall after reloads.
                if (sclk_fall && state == ST_RDATA) begin
                    out_cnt <= out_cnt + 3'd1;
                    if (out_cnt == 3'd0) begin
                        shift_out <= is_rdid ? DEVICE_ID : mem[ptr];
                        if (!is_rdid) ptr <= ptr + ADDR_W'(1);
                    end else begin
                        shift_out <= {shift_out[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_miso_oeb_o = (state == ST_IDLE) | cs_n;
    assign spi_miso_o     = (state == ST_RDATA) & ~cs_n & shift_out[7];
    assign busy_o         = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_target_mem.sv
// Self-checking bench for spi_target_mem: random SPI transactions against an array model.
module tb_spi_target_mem;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int          HALF  = 80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          cs = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic          oeb;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          err;

    spi_target_mem #(.ADDR_W(AW), .DEVICE_ID(8'hA5)) dut (
        .wb_clk_i       (clk),
        .wb_rst_n_i     (rst_n),
        .spi_clk_i      (sclk),
        .spi_cs_i       (cs),
        .spi_mosi_i     (mosi),
        .spi_miso_o     (miso),
        .spi_miso_oeb_o (oeb),
        .wr_stb_o       (wr_stb),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .busy_o         (busy),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [7:0]  model [DEPTH];

    logic [AW-1:0] obs_addr_q [$];
    logic [7:0]    obs_data_q [$];
    int unsigned   err_cnt = 0;
    int unsigned   miso_hi_cnt = 0;

    always @(negedge clk) begin
        if (wr_stb) begin
            obs_addr_q.push_back(wr_addr);
            obs_data_q.push_back(wr_data);
        end
        if (err) err_cnt++;
        if (miso) miso_hi_cnt++;
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            #(HALF);
            sclk = 1'b1;
            rx = {rx[6:0], miso};
            #(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        cs = 1'b0;
        #(HALF);
    endtask

    task automatic cs_end();
        #(HALF);
        cs = 1'b1;
        #(4*HALF);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] d [$]);
        logic [7:0] rx;
        cs_start();
        spi_bits(8'h02, 8, rx);
        spi_bits(addr, 8, rx);
        foreach (d[i]) begin
            spi_bits(d[i], 8, rx);
            model[(int'(addr) + i) % DEPTH] = d[i];
        end
        cs_end();
    endtask

    task automatic do_read(input logic [7:0] addr, input int n, output logic [7:0] q [$]);
        logic [7:0] rx;
        q = {};
        cs_start();
        spi_bits(8'h03, 8, rx);
        spi_bits(addr, 8, rx);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, rx);
            q.push_back(rx);
        end
        cs_end();
    endtask

    task automatic write_then_read(input string tag, input logic [7:0] addr, input logic [7:0] d [$]);
        int unsigned base;
        logic [7:0]  got [$];
        base = obs_addr_q.size();
        do_write(addr, d);
        tests++;
        if (obs_addr_q.size() !== base + d.size()) begin
            fails++;
            $display("FAIL %s strobe_count got %0d want %0d", tag, obs_addr_q.size() - base, d.size());
        end else begin
            foreach (d[i]) begin
                tests++;
                if (obs_addr_q[base+i] !== AW'((int'(addr) + i) % DEPTH) || obs_data_q[base+i] !== d[i]) begin
                    fails++;
                    $display("FAIL %s strobe[%0d] got (%0h,%0h) want (%0h,%0h)", tag, i,
                             obs_addr_q[base+i], obs_data_q[base+i], (int'(addr) + i) % DEPTH, d[i]);
                end
            end
        end
        do_read(addr, d.size(), got);
        foreach (d[i]) begin
            tests++;
            if (got[i] !== model[(int'(addr) + i) % DEPTH]) begin
                fails++;
                $display("FAIL %s readback[%0d] got %0h want %0h", tag, i, got[i], model[(int'(addr) + i) % DEPTH]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if ({miso, oeb, wr_stb, wr_addr, wr_data, busy, err} !== {1'b0, 1'b1, 1'b0, {AW{1'b0}}, 8'h00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL %s outputs miso=%b oeb=%b stb=%b addr=%0h data=%0h busy=%b err=%b want 0 1 0 0 0 0 0",
                     tag, miso, oeb, wr_stb, wr_addr, wr_data, busy, err);
        end
    endtask

    task automatic test_reset();
        foreach (model[i]) model[i] = 8'h00;
        #1;
        check_reset_outputs("reset");
        #30;
        rst_n = 1'b1;
        #(4*HALF);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_write_read();
        logic [7:0] d [$];
        d = {8'h11, 8'h22};
        write_then_read("wr_basic", 8'h03, d);
        d = {};
        for (int i = 0; i < 3; i++) d.push_back(8'($urandom));
        // upper address bits are don't-care
        write_then_read("wr_rand", 8'($urandom), d);
    endtask

    task automatic test_wrap();
        logic [7:0] d [$];
        d = {8'hAA, 8'hBB};
        write_then_read("wrap", 8'h0F, d);
        tests++;
        if (model[15] !== 8'hAA || model[0] !== 8'hBB) begin
            fails++;
            $display("FAIL wrap_model got %0h,%0h want aa,bb", model[15], model[0]);
        end
    endtask

    task automatic test_bad_opcode();
        int unsigned e0, m0, s0;
        logic [7:0]  rx;
        e0 = err_cnt; m0 = miso_hi_cnt; s0 = obs_addr_q.size();
        cs_start();
        spi_bits(8'h55, 8, rx);
        #(HALF);
        tests++;
        if (busy !== 1'b1 || oeb !== 1'b0) begin
            fails++;
            $display("FAIL badop_drive busy=%b oeb=%b want 1 0", busy, oeb);
        end
        spi_bits(8'($urandom), 8, rx);
        spi_bits(8'($urandom), 8, rx);
        cs_end();
        tests++;
        if (err_cnt - e0 !== 1) begin
            fails++;
            $display("FAIL badop_err pulses got %0d want 1", err_cnt - e0);
        end
        tests++;
        if (miso_hi_cnt !== m0 || obs_addr_q.size() !== s0) begin
            fails++;
            $display("FAIL badop_quiet miso_hi=%0d strobes=%0d want 0 0", miso_hi_cnt - m0, obs_addr_q.size() - s0);
        end
    endtask

    task automatic test_rdid();
        int unsigned e0, m0;
        logic [7:0]  rx;
        e0 = err_cnt; m0 = miso_hi_cnt;
        cs_start();
        spi_bits(8'h9F, 8, rx);
`ifdef SPI_TARGET_RDID_EN
        for (int i = 0; i < 3; i++) begin
            spi_bits(8'h00, 8, rx);
            tests++;
            if (rx !== 8'hA5) begin
                fails++;
                $display("FAIL rdid[%0d] got %0h want a5", i, rx);
            end
        end
        cs_end();
        tests++;
        if (err_cnt !== e0) begin
            fails++;
            $display("FAIL rdid_err pulses got %0d want 0", err_cnt - e0);
        end
`else
        for (int i = 0; i < 3; i++) spi_bits(8'h00, 8, rx);
        cs_end();
        tests++;
        if (err_cnt - e0 !== 1 || miso_hi_cnt !== m0) begin
            fails++;
            $display("FAIL rdid_disabled err=%0d miso_hi=%0d want 1 0", err_cnt - e0, miso_hi_cnt - m0);
        end
`endif
    endtask

    task automatic test_abort();
        int unsigned s0;
        logic [7:0]  rx;
        logic [7:0]  a;
        logic [7:0]  got [$];
        a  = 8'($urandom_range(0, DEPTH-1));
        s0 = obs_addr_q.size();
        cs_start();
        spi_bits(8'h02, 8, rx);
        spi_bits(a, 8, rx);
        spi_bits(~model[a[AW-1:0]], 5, rx);
        @(negedge clk);
        cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (oeb !== 1'b1) begin
            fails++;
            $display("FAIL abort_oeb got %b want 1", oeb);
        end
        #(4*HALF);
        tests++;
        if (obs_addr_q.size() !== s0) begin
            fails++;
            $display("FAIL abort_strobe got %0d want 0", obs_addr_q.size() - s0);
        end
        do_read(a, 1, got);
        tests++;
        if (got[0] !== model[a[AW-1:0]]) begin
            fails++;
            $display("FAIL abort_mem got %0h want %0h", got[0], model[a[AW-1:0]]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [$];
        for (int t = 0; t < 5; t++) begin
            d = {};
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) d.push_back(8'($urandom));
            write_then_read("b2b", 8'($urandom), d);
        end
    endtask

    task automatic test_reset_mid_read();
        int unsigned e0;
        logic [7:0]  rx;
        logic [7:0]  got [$];
        logic [7:0]  a;
        cs_start();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 4, rx);
        #23;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_read_reset");
        foreach (model[i]) model[i] = 8'h00;
        #50;
        rst_n = 1'b1;
        e0 = err_cnt;
        spi_bits(8'h55, 8, rx);
        spi_bits(8'h9F, 8, rx);
        tests++;
        if (busy !== 1'b0 || oeb !== 1'b1 || err_cnt !== e0) begin
            fails++;
            $display("FAIL no_resume busy=%b oeb=%b err=%0d want 0 1 0", busy, oeb, err_cnt - e0);
        end
        cs_end();
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom);
            do_read(a, 1, got);
            tests++;
            if (got[0] !== model[a[AW-1:0]]) begin
                fails++;
                $display("FAIL cleared_mem[%0h] got %0h want %0h", a[AW-1:0], got[0], model[a[AW-1:0]]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_bad_opcode();
        test_rdid();
        test_abort();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
